wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 68 ++++++
 tb/tb_wb_regfile.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 x 32 array with two combinational read
// ports, a write-through bypass, jump-link destination override and a
// counter of committed writes. Entry 0 is hard-wired to zero.
module wb_regfile #(
  parameter int LINK_REG = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic        memToReg,
  input  logic        regWrite,
  input  logic [31:0] readData,
  input  logic [31:0] aluResult,
  input  logic [4:0]  writeRegistrer,
  input  logic [31:0] linkPC,
  input  logic [4:0]  readReg1,
  input  logic [4:0]  readReg2,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] wbData,
  output logic [31:0] wbCount
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  logic [31:0] regs [32];
  logic [4:0]  wb_dest;
  logic        commit;
  logic        byp1;
  logic        byp2;

  // Write-back source select and destination override; a jump-link wins over
  // everything else so the return address always lands in the link register.
  always_comb begin
    wbData  = jump ? linkPC : (memToReg ? readData : aluResult);
    wb_dest = jump ? LINK_IDX : writeRegistrer;
    commit  = regWrite && (wb_dest != 5'd0);
  end

  // Read ports with independent bypass; the bypass stays live during reset
  // because it only depends on the current write-back inputs.
  always_comb begin
    byp1 = commit && (readReg1 == wb_dest);
    byp2 = commit && (readReg2 == wb_dest);
    if (byp1)                  readData1 = wbData;
    else if (readReg1 == 5'd0) readData1 = 32'd0;
    else                       readData1 = regs[readReg1];
    if (byp2)                  readData2 = wbData;
    else if (readReg2 == 5'd0) readData2 = 32'd0;
    else                       readData2 = regs[readReg2];
  end

  // Array update: cleared asynchronously, otherwise one write per committed cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (commit) begin
      regs[wb_dest] <= wbData;
    end
  end

  // Committed-write counter, free-running wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wbCount <= 32'd0;
    else if (commit) wbCount <= wbCount + 32'd1;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values are queued as stimulus is
// applied and popped when the corresponding output is sampled.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        jump;
  logic        memToReg;
  logic        regWrite;
  logic [31:0] readData;
  logic [31:0] aluResult;
  logic [4:0]  writeRegistrer;
  logic [31:0] linkPC;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] wbData;
  logic [31:0] wbCount;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  wb_regfile #(.LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .jump(jump), .memToReg(memToReg), .regWrite(regWrite),
    .readData(readData), .aluResult(aluResult), .writeRegistrer(writeRegistrer),
    .linkPC(linkPC), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2), .wbData(wbData), .wbCount(wbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    jump = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
    readData = 32'd0; aluResult = 32'd0; writeRegistrer = 5'd0; linkPC = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    readReg1 = 5'd0;
    readReg2 = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    #1;
    expect_val("rst_r0", 32'd0);   check(readData1);
    expect_val("rst_r5", 32'd0);   check(readData2);
    readReg1 = 5'd31;
    #1;
    expect_val("rst_r31", 32'd0);  check(readData1);
    expect_val("rst_cnt", 32'd0);  check(wbCount);

    // ALU write with bypass
    @(negedge clk);
    regWrite = 1'b1; aluResult = 32'h12345678; readData = 32'h0BADF00D;
    writeRegistrer = 5'd5; readReg1 = 5'd5; readReg2 = 5'd6;
    #1;
    expect_val("alu_bypass", 32'h12345678); check(readData1);
    expect_val("alu_nobyp_r6", 32'd0);      check(readData2);
    @(negedge clk);
    idle();
    #1;
    expect_val("alu_after", 32'h12345678); check(readData1);
    expect_val("alu_cnt", 32'd1);          check(wbCount);

    // load write
    @(negedge clk);
    regWrite = 1'b1; memToReg = 1'b1; readData = 32'hDEADBEEF;
    aluResult = 32'h11111111; writeRegistrer = 5'd7; readReg2 = 5'd7;
    #1;
    expect_val("load_wbdata", 32'hDEADBEEF); check(wbData);
    @(negedge clk);
    idle();
    #1;
    expect_val("load_r7", 32'hDEADBEEF); check(readData2);
    expect_val("load_cnt", 32'd2);       check(wbCount);

    // jump-link write, memToReg set to confirm jump has priority
    @(negedge clk);
    jump = 1'b1; regWrite = 1'b1; memToReg = 1'b1; readData = 32'h22222222;
    linkPC = 32'h00400010; writeRegistrer = 5'd3; readReg1 = 5'd31; readReg2 = 5'd3;
    #1;
    expect_val("jal_wbdata", 32'h00400010); check(wbData);
    expect_val("jal_bypass31", 32'h00400010); check(readData1);
    expect_val("jal_nobyp3", 32'd0);        check(readData2);
    @(negedge clk);
    idle();
    #1;
    expect_val("jal_r31", 32'h00400010); check(readData1);
    expect_val("jal_r3", 32'd0);         check(readData2);
    expect_val("jal_cnt", 32'd3);        check(wbCount);

    // write to index 0 is discarded
    @(negedge clk);
    regWrite = 1'b1; aluResult = 32'hAAAAAAAA; writeRegistrer = 5'd0; readReg1 = 5'd0;
    #1;
    expect_val("r0_nobyp", 32'd0); check(readData1);
    @(negedge clk);
    idle();
    #1;
    expect_val("r0_after", 32'd0); check(readData1);
    expect_val("r0_cnt", 32'd3);   check(wbCount);

    // disabled writes, including a disabled jump
    @(negedge clk);
    regWrite = 1'b0; jump = 1'b1; linkPC = 32'h99999999;
    aluResult = 32'h55555555; writeRegistrer = 5'd9; readReg1 = 5'd9; readReg2 = 5'd31;
    #1;
    expect_val("dis_r9_pre", 32'd0);         check(readData1);
    expect_val("dis_r31_pre", 32'h00400010); check(readData2);
    @(negedge clk);
    idle();
    #1;
    expect_val("dis_r9", 32'd0);         check(readData1);
    expect_val("dis_r31", 32'h00400010); check(readData2);
    expect_val("dis_cnt", 32'd3);        check(wbCount);

    // both ports on the same index, overwrite with bypass on each
    @(negedge clk);
    regWrite = 1'b1; aluResult = 32'hCAFEF00D; writeRegistrer = 5'd5;
    readReg1 = 5'd5; readReg2 = 5'd5;
    #1;
    expect_val("dual_byp1", 32'hCAFEF00D); check(readData1);
    expect_val("dual_byp2", 32'hCAFEF00D); check(readData2);
    @(negedge clk);
    idle();
    #1;
    expect_val("dual_r1", 32'hCAFEF00D); check(readData1);
    expect_val("dual_r2", 32'hCAFEF00D); check(readData2);
    expect_val("dual_cnt", 32'd4);       check(wbCount);

    // asynchronous reset between edges; bypass still live; edge write lost
    @(negedge clk);
    #2;
    rst = 1'b1;
    readReg1 = 5'd5; readReg2 = 5'd31;
    #1;
    expect_val("arst_r5", 32'd0);  check(readData1);
    expect_val("arst_r31", 32'd0); check(readData2);
    expect_val("arst_cnt", 32'd0); check(wbCount);
    regWrite = 1'b1; aluResult = 32'h77777777; writeRegistrer = 5'd10; readReg1 = 5'd10;
    #1;
    expect_val("arst_bypass", 32'h77777777); check(readData1);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    expect_val("arst_lost_r10", 32'd0); check(readData1);
    expect_val("arst_lost_cnt", 32'd0); check(wbCount);

    // counter wrap
    @(negedge clk);
    force dut.wbCount = 32'hFFFFFFFF;
    #1;
    release dut.wbCount;
    #1;
    expect_val("wrap_pre", 32'hFFFFFFFF); check(wbCount);
    regWrite = 1'b1; aluResult = 32'h00000044; writeRegistrer = 5'd4; readReg1 = 5'd4;
    @(negedge clk);
    idle();
    #1;
    expect_val("wrap_cnt", 32'd0);        check(wbCount);
    expect_val("wrap_r4", 32'h00000044);  check(readData1);

    if (sb.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
